// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing control for the five-stage pipeline, with mul/div hold FSM and stall counter.
module pipeline_ctrl #(
  parameter int MULDIV_LAT = 34
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic        ex_load_i,
  input  logic        ex_wen_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_muldiv_i,
  input  logic        ex_redirect_i,
  input  logic        wb_exception_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic [1:0]  pc_sel_o,
  output logic        muldiv_done_o,
  output logic [31:0] stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic lu, md_hold;
  assign lu = ex_load_i & ex_wen_i & (ex_rd_i != 5'd0) &
              ((id_rs1_ren_i & (id_rs1_i == ex_rd_i)) | (id_rs2_ren_i & (id_rs2_i == ex_rd_i)));
  assign md_hold = (state == BUSY) | ((state == IDLE) & ex_muldiv_i);
  assign muldiv_done_o = (state == DONE) & ~reset;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (ex_muldiv_i) begin
        state_nxt = (MULDIV_LAT == 2) ? DONE : BUSY;
        cnt_nxt = 8'(MULDIV_LAT - 2);
      end
      BUSY: begin
        cnt_nxt = cnt - 8'd1;
        state_nxt = (cnt <= 8'd1) ? DONE : BUSY;
      end
      default: state_nxt = IDLE;
    endcase
    if (wb_exception_i) begin
      state_nxt = IDLE;
      cnt_nxt = 8'd0;
    end
  end
  // Priority: trap, mul/div hold, redirect, load-use.
  always_comb begin
    pc_stall_o = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_mem_flush_o = 1'b0;
    pc_sel_o = 2'd0;
    if (reset) begin
      pc_sel_o = 2'd0;
    end else if (wb_exception_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      ex_mem_flush_o = 1'b1;
      pc_sel_o = 2'd2;
    end else if (md_hold) begin
      pc_stall_o = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_stall_o = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (ex_redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      pc_sel_o = 2'd1;
    end else if (lu) begin
      pc_stall_o = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (pc_stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with an expected-response queue checked by a negedge monitor.
module tb_pipeline_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic id_rs1_ren_i, id_rs2_ren_i, ex_load_i, ex_wen_i, ex_muldiv_i, ex_redirect_i, wb_exception_i;
  logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, ex_mem_flush_o, muldiv_done_o;
  logic [1:0] pc_sel_o;
  logic [31:0] stall_cnt_o;

  pipeline_ctrl #(.MULDIV_LAT(34)) dut (
    .clock(clock), .reset(reset),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .ex_load_i(ex_load_i), .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i),
    .ex_muldiv_i(ex_muldiv_i), .ex_redirect_i(ex_redirect_i), .wb_exception_i(wb_exception_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_stall_o(id_ex_stall_o), .id_ex_flush_o(id_ex_flush_o), .ex_mem_flush_o(ex_mem_flush_o),
    .pc_sel_o(pc_sel_o), .muldiv_done_o(muldiv_done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clock = ~clock;

  // Output vector: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, pc_sel[1:0], done}
  localparam logic [8:0] O_NONE = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] O_LU   = 9'b1_1_0_0_1_0_00_0;
  localparam logic [8:0] O_MD   = 9'b1_1_0_1_0_1_00_0;
  localparam logic [8:0] O_RD   = 9'b0_0_1_0_1_0_01_0;
  localparam logic [8:0] O_TR   = 9'b0_0_1_0_1_1_10_0;
  localparam logic [8:0] O_DN   = 9'b0_0_0_0_0_0_00_1;

  typedef struct {
    logic [8:0]  o;
    logic [31:0] c;
    string       n;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
             ex_mem_flush_o, pc_sel_o, muldiv_done_o};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL %s: outputs got %b expected %b", e.n, act, e.o);
      end
      checks++;
      if (stall_cnt_o !== e.c) begin
        errors++;
        $display("FAIL %s: stall_cnt got %h expected %h", e.n, stall_cnt_o, e.c);
      end
    end
  end

  task automatic clr();
    id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
    id_rs1_ren_i = 0; id_rs2_ren_i = 0; ex_load_i = 0; ex_wen_i = 0;
    ex_muldiv_i = 0; ex_redirect_i = 0; wb_exception_i = 0;
  endtask

  task automatic cyc(input string n, input logic [8:0] e);
    q.push_back('{o: e, c: exp_cnt, n: n});
    @(posedge clock);
    #1;
    if (reset) exp_cnt = 32'd0;
    else if (e[8] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic r1en,
                          input logic [4:0] rs2, input logic r2en);
    ex_load_i = 1; ex_wen_i = 1; ex_rd_i = rd;
    id_rs1_i = rs1; id_rs1_ren_i = r1en; id_rs2_i = rs2; id_rs2_ren_i = r2en;
  endtask

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    cyc("reset", O_NONE);
    reset = 0;

    load_use(5, 5, 1, 0, 0);
    cyc("lu_rs1", O_LU);
    clr();
    cyc("lu_after", O_NONE);
    load_use(0, 0, 1, 0, 0);
    cyc("lu_rd0", O_NONE);
    load_use(7, 0, 0, 7, 1);
    cyc("lu_rs2", O_LU);
    load_use(7, 0, 0, 7, 0);
    cyc("lu_noren", O_NONE);
    clr();

    ex_muldiv_i = 1;
    for (int i = 0; i < 33; i++) cyc("md1_stall", O_MD);
    cyc("md1_done", O_DN);
    for (int i = 0; i < 33; i++) cyc("md2_stall", O_MD);
    cyc("md2_done", O_DN);
    ex_muldiv_i = 0;
    cyc("md_idle", O_NONE);

    ex_redirect_i = 1;
    cyc("redirect", O_RD);
    load_use(5, 5, 1, 0, 0);
    cyc("redirect_lu", O_RD);
    clr();
    cyc("redirect_after", O_NONE);

    ex_muldiv_i = 1;
    cyc("trap_md_idle", O_MD);
    for (int i = 0; i < 9; i++) cyc("trap_md_busy", O_MD);
    wb_exception_i = 1;
    cyc("trap", O_TR);
    clr();
    for (int i = 0; i < 40; i++) cyc("trap_after", O_NONE);

    ex_muldiv_i = 1;
    for (int i = 0; i < 20; i++) cyc("rst_md_stall", O_MD);
    reset = 1;
    cyc("rst_busy", O_NONE);
    reset = 0;
    for (int i = 0; i < 33; i++) cyc("rst_md_stall2", O_MD);
    cyc("rst_md_done", O_DN);
    ex_muldiv_i = 0;
    cyc("rst_md_idle", O_NONE);

    force dut.stall_cnt_o = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_o;
    exp_cnt = 32'hFFFF_FFFE;
    ex_muldiv_i = 1;
    for (int i = 0; i < 33; i++) cyc("sat_stall", O_MD);
    cyc("sat_done", O_DN);
    ex_muldiv_i = 0;
    cyc("sat_final", O_NONE);

    repeat (2) @(posedge clock);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
